life_engine_2d: RTL and testbench

Parametrised cellular-automaton engine: the successor to the fixed 8x8 Game of Life core. It holds a ROWS x COLS grid and advances one generation per qualifying `tick`. Boundary handling (toroidal or dead edge), run/pause/single-step control, bulk load, generation counting, population count and still-life/extinction detection are all built in. It sits between the slow tick divider and the LED-matrix / display driver, which consumes `grid_out`.

---
 rtl/life_engine_2d.sv | 187 ++++++++++++++++++
 tb/tb_life_engine_2d.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine_2d.sv
// life_engine_2d: ROWS x COLS Game of Life (B3/S23) engine.
// Provides run/pause/single-step control, bulk load, a saturating generation
// counter, a population count and still-life/extinction flags.
// All outputs are direct images of registers.
module life_engine_2d #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int WRAP      = 1,
  parameter int AUTO_HALT = 1,
  parameter int GEN_W     = 16,
  parameter logic [ROWS*COLS-1:0] INIT_GRID = {(ROWS*COLS){1'b1}}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tick,
  input  logic                             cmd_run,
  input  logic                             cmd_pause,
  input  logic                             cmd_step,
  input  logic                             load_valid,
  input  logic [ROWS*COLS-1:0]             load_data,
  output logic [ROWS*COLS-1:0]             grid_out,
  output logic                             running,
  output logic [GEN_W-1:0]                 gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]   pop_count,
  output logic                             stable,
  output logic                             extinct
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N + 1);

  typedef enum logic [0:0] {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  // Number of set bits in a full grid image.
  function automatic logic [PW-1:0] popcount(input logic [N-1:0] v);
    logic [N-1:0]  t;
    logic [PW-1:0] p;
    t = v;
    p = {PW{1'b0}};
    for (int i = 32'sd0; i < N; i++) begin
      p = p + PW'(t[0]);
      t = t >> 1'b1;
    end
    return p;
  endfunction

  // Number of live cells among the eight neighbours of one cell.
  function automatic logic [3:0] count8(input logic [7:0] v);
    return {3'b000, v[0]} + {3'b000, v[1]} + {3'b000, v[2]} + {3'b000, v[3]}
         + {3'b000, v[4]} + {3'b000, v[5]} + {3'b000, v[6]} + {3'b000, v[7]};
  endfunction

  state_t           state_r, state_nxt_s;
  logic             step_pending_r, step_nxt_s;
  logic [N-1:0]     grid_r, grid_nxt_s;
  logic [GEN_W-1:0] gen_r, gen_nxt_s;
  logic [PW-1:0]    pop_r, pop_nxt_s;
  logic             stable_r, stable_nxt_s;
  logic             extinct_r, extinct_nxt_s;
  logic [N-1:0]     next_s;
  logic             same_s;
  logic             do_update_s;

  // Per-cell B3/S23 rule; neighbour indices and edge masks are resolved at
  // elaboration so the datapath is pure wiring plus a small adder per cell.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RN = (r + ROWS - 1) % ROWS;
      localparam int RS = (r + 1) % ROWS;
      localparam int CW = (c + COLS - 1) % COLS;
      localparam int CE = (c + 1) % COLS;
      localparam bit HN = (WRAP != 0) || (r > 0);
      localparam bit HS = (WRAP != 0) || (r < ROWS - 1);
      localparam bit HW = (WRAP != 0) || (c > 0);
      localparam bit HE = (WRAP != 0) || (c < COLS - 1);

      logic [7:0] nb_s;
      logic [3:0] cnt_s;

      assign nb_s[0] = (HN)       ? grid_r[RN*COLS + c ] : 1'b0;
      assign nb_s[1] = (HS)       ? grid_r[RS*COLS + c ] : 1'b0;
      assign nb_s[2] = (HW)       ? grid_r[r*COLS  + CW] : 1'b0;
      assign nb_s[3] = (HE)       ? grid_r[r*COLS  + CE] : 1'b0;
      assign nb_s[4] = (HN && HW) ? grid_r[RN*COLS + CW] : 1'b0;
      assign nb_s[5] = (HN && HE) ? grid_r[RN*COLS + CE] : 1'b0;
      assign nb_s[6] = (HS && HW) ? grid_r[RS*COLS + CW] : 1'b0;
      assign nb_s[7] = (HS && HE) ? grid_r[RS*COLS + CE] : 1'b0;
      assign cnt_s   = count8(nb_s);
      assign next_s[r*COLS + c] = (cnt_s == 4'd3) | (grid_r[r*COLS + c] & (cnt_s == 4'd2));
    end
  end

  assign same_s = (next_s == grid_r);

  // Next-state for control and datapath: load beats pause beats run/step;
  // the update decision uses the state as it was before this edge.
  always_comb begin
    state_nxt_s   = state_r;
    step_nxt_s    = step_pending_r;
    grid_nxt_s    = grid_r;
    gen_nxt_s     = gen_r;
    pop_nxt_s     = pop_r;
    stable_nxt_s  = stable_r;
    extinct_nxt_s = extinct_r;
    do_update_s   = 1'b0;
    if (load_valid) begin
      grid_nxt_s    = load_data;
      gen_nxt_s     = {GEN_W{1'b0}};
      stable_nxt_s  = 1'b0;
      extinct_nxt_s = (load_data == {N{1'b0}});
      pop_nxt_s     = popcount(load_data);
      state_nxt_s   = PAUSED;
      step_nxt_s    = 1'b0;
    end else if (cmd_pause) begin
      state_nxt_s = PAUSED;
      step_nxt_s  = 1'b0;
    end else begin
      do_update_s = tick & ((state_r == RUNNING) | step_pending_r);
      case (state_r)
        PAUSED: begin
          if (cmd_run) begin
            state_nxt_s = RUNNING;
            step_nxt_s  = 1'b0;
          end else if (cmd_step) begin
            step_nxt_s = 1'b1;
          end else begin
            step_nxt_s = step_pending_r;
          end
        end
        RUNNING: begin
          state_nxt_s = RUNNING;
        end
        default: begin
          state_nxt_s = PAUSED;
          step_nxt_s  = 1'b0;
        end
      endcase
      if (do_update_s) begin
        grid_nxt_s    = next_s;
        gen_nxt_s     = (gen_r == {GEN_W{1'b1}}) ? gen_r : gen_r + {{(GEN_W-1){1'b0}}, 1'b1};
        stable_nxt_s  = same_s;
        extinct_nxt_s = (next_s == {N{1'b0}});
        pop_nxt_s     = popcount(next_s);
        step_nxt_s    = 1'b0;
        if ((state_r == RUNNING) && (AUTO_HALT != 0) && same_s) begin
          state_nxt_s = PAUSED;
        end else begin
          state_nxt_s = state_nxt_s;
        end
      end else begin
        grid_nxt_s = grid_r;
      end
    end
  end

  // State and datapath registers with asynchronous reset to the initial image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= PAUSED;
      step_pending_r <= 1'b0;
      grid_r         <= INIT_GRID;
      gen_r          <= {GEN_W{1'b0}};
      pop_r          <= popcount(INIT_GRID);
      stable_r       <= 1'b0;
      extinct_r      <= (INIT_GRID == {N{1'b0}});
    end else begin
      state_r        <= state_nxt_s;
      step_pending_r <= step_nxt_s;
      grid_r         <= grid_nxt_s;
      gen_r          <= gen_nxt_s;
      pop_r          <= pop_nxt_s;
      stable_r       <= stable_nxt_s;
      extinct_r      <= extinct_nxt_s;
    end
  end

  assign grid_out  = grid_r;
  assign running   = (state_r == RUNNING);
  assign gen_count = gen_r;
  assign pop_count = pop_r;
  assign stable    = stable_r;
  assign extinct   = extinct_r;

endmodule

// File: tb/tb_life_engine_2d.sv
// Testbench for life_engine_2d: three 8x8 instances (toroidal, dead-edge,
// dead-edge with 2-bit generation counter) share one stimulus stream and are
// compared every cycle against a cell-by-cell reference model.
module tb_life_engine_2d;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        cmd_run = 1'b0;
  logic        cmd_pause = 1'b0;
  logic        cmd_step = 1'b0;
  logic        load_valid = 1'b0;
  logic [63:0] load_data = 64'd0;

  logic [63:0] go_w, go_d, go_s;
  logic        run_w, run_d, run_s;
  logic [15:0] gen_w, gen_d;
  logic [1:0]  gen_s;
  logic [6:0]  pop_w, pop_d, pop_s;
  logic        st_w, st_d, st_s;
  logic        ex_w, ex_d, ex_s;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [63:0] grid;
    bit          run;
    bit          pend;
    int          gen;
    bit          stable;
  } mstate_t;

  mstate_t m[3];
  bit      wraps[3] = '{1'b1, 1'b0, 1'b0};
  int      gmax[3]  = '{65535, 65535, 3};
  string   iname[3] = '{"wrap", "dead", "sat"};

  life_engine_2d #(.WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .tick(tick), .cmd_run(cmd_run), .cmd_pause(cmd_pause),
    .cmd_step(cmd_step), .load_valid(load_valid), .load_data(load_data),
    .grid_out(go_w), .running(run_w), .gen_count(gen_w), .pop_count(pop_w),
    .stable(st_w), .extinct(ex_w));

  life_engine_2d #(.WRAP(0)) u_dead (
    .clk(clk), .rst(rst), .tick(tick), .cmd_run(cmd_run), .cmd_pause(cmd_pause),
    .cmd_step(cmd_step), .load_valid(load_valid), .load_data(load_data),
    .grid_out(go_d), .running(run_d), .gen_count(gen_d), .pop_count(pop_d),
    .stable(st_d), .extinct(ex_d));

  life_engine_2d #(.WRAP(0), .GEN_W(2)) u_sat (
    .clk(clk), .rst(rst), .tick(tick), .cmd_run(cmd_run), .cmd_pause(cmd_pause),
    .cmd_step(cmd_step), .load_valid(load_valid), .load_data(load_data),
    .grid_out(go_s), .running(run_s), .gen_count(gen_s), .pop_count(pop_s),
    .stable(st_s), .extinct(ex_s));

  always #5 clk = ~clk;

  // Reference next generation: count the eight neighbours of every cell.
  function automatic logic [63:0] life_next(input logic [63:0] g, input bit wrap);
    logic [63:0] nx;
    int n, rr, cc;
    nx = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (wrap) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
              continue;
            end
            if (g[rr*8 + cc]) n++;
          end
        end
        if (g[r*8 + c]) nx[r*8 + c] = (n == 2 || n == 3);
        else            nx[r*8 + c] = (n == 3);
      end
    end
    return nx;
  endfunction

  // Reference control behaviour for one cycle of one instance.
  function automatic mstate_t model_step(input mstate_t s, input int k);
    mstate_t     o;
    logic [63:0] nx;
    bit          upd;
    o = s;
    if (load_valid) begin
      o.grid = load_data; o.gen = 0; o.stable = 1'b0; o.run = 1'b0; o.pend = 1'b0;
      return o;
    end
    if (cmd_pause) begin
      o.run = 1'b0; o.pend = 1'b0;
      return o;
    end
    upd = tick && (s.run || s.pend);
    if (!s.run && cmd_run) begin
      o.run = 1'b1; o.pend = 1'b0;
    end else if (!s.run && cmd_step) begin
      o.pend = 1'b1;
    end
    if (upd) begin
      nx = life_next(s.grid, wraps[k]);
      o.stable = (nx == s.grid);
      o.grid   = nx;
      if (s.gen < gmax[k]) o.gen = s.gen + 1;
      o.pend = 1'b0;
      if (s.run && nx == s.grid) o.run = 1'b0;
    end
    return o;
  endfunction

  // Advance the reference model alongside the DUTs.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) m[k] <= '{grid: {64{1'b1}}, run: 1'b0, pend: 1'b0, gen: 0, stable: 1'b0};
      else     m[k] <= model_step(m[k], k);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_inst(input int k, input logic [63:0] g, input logic r,
                              input logic [15:0] gen, input logic [6:0] pop,
                              input logic st, input logic ex);
    chk({iname[k], ".grid"},    g,            m[k].grid);
    chk({iname[k], ".running"}, 64'(r),       64'(m[k].run));
    chk({iname[k], ".gen"},     64'(gen),     64'(m[k].gen));
    chk({iname[k], ".pop"},     64'(pop),     64'($countones(m[k].grid)));
    chk({iname[k], ".stable"},  64'(st),      64'(m[k].stable));
    chk({iname[k], ".extinct"}, 64'(ex),      64'(m[k].grid == 64'd0));
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      compare_inst(0, go_w, run_w, gen_w, pop_w, st_w, ex_w);
      compare_inst(1, go_d, run_d, gen_d, pop_d, st_d, ex_d);
      compare_inst(2, go_s, run_s, {14'd0, gen_s}, pop_s, st_s, ex_s);
    end
  end

  task automatic drive(input bit ld, input logic [63:0] d, input bit tk,
                       input bit rn, input bit ps, input bit sp);
    load_valid = ld; load_data = d; tick = tk;
    cmd_run = rn; cmd_pause = ps; cmd_step = sp;
    @(negedge clk);
    load_valid = 1'b0; tick = 1'b0; cmd_run = 1'b0; cmd_pause = 1'b0; cmd_step = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("reset.grid",    go_w,        {64{1'b1}});
    chk("reset.pop",     64'(pop_w),  64'd64);
    chk("reset.gen",     64'(gen_w),  64'd0);
    chk("reset.running", 64'(run_w),  64'd0);
    chk("reset.extinct", 64'(ex_w),   64'd0);
    chk("reset.stable",  64'(st_w),   64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Blinker on the dead-edge instance
    drive(1'b1, 64'h1C000000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("blinker.grid",    go_d,        64'h0000000808080000);
    chk("blinker.gen",     64'(gen_d),  64'd1);
    chk("blinker.pop",     64'(pop_d),  64'd3);
    chk("blinker.stable",  64'(st_d),   64'd0);
    chk("blinker.running", 64'(run_d),  64'd0);

    // Row-0 edge, wrap vs dead
    drive(1'b1, 64'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("edge.wrap.grid", go_w,        64'h0200000000000202);
    chk("edge.wrap.pop",  64'(pop_w),  64'd3);
    chk("edge.dead.grid", go_d,        64'h202);
    chk("edge.dead.pop",  64'(pop_d),  64'd2);

    // Still life halts the run
    drive(1'b1, 64'h303, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("halt.grid",    go_w,        64'h303);
    chk("halt.gen",     64'(gen_w),  64'd1);
    chk("halt.stable",  64'(st_w),   64'd1);
    chk("halt.running", 64'(run_w),  64'd0);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("halt.gen2",    64'(gen_w),  64'd1);

    // Load beats run and tick; pause beats run
    drive(1'b1, 64'h1C000000, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("prio.grid",    go_w,        64'h1C000000);
    chk("prio.gen",     64'(gen_w),  64'd0);
    chk("prio.running", 64'(run_w),  64'd0);
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("prio.pause",   64'(run_w),  64'd0);

    // Saturating 2-bit counter with a running blinker
    drive(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("sat.gen",  64'(gen_s),  64'd3);
    chk("sat.grid", go_s,        64'h0000000808080000);
    chk("sat.wide", 64'(gen_w),  64'd5);

    // Asynchronous reset between edges while running at generation 7
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid.gen7",    64'(gen_w),  64'd7);
    chk("mid.running", 64'(run_w),  64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.grid",    go_w,        {64{1'b1}});
    chk("rst.gen",     64'(gen_w),  64'd0);
    chk("rst.running", 64'(run_w),  64'd0);
    chk("rst.pop",     64'(pop_w),  64'd64);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomised control and data stream
    for (int i = 0; i < 4000; i++) begin
      logic [63:0] d;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      d = {$urandom, $urandom} & {$urandom, $urandom};
      else if (sel == 1) d = {$urandom, $urandom};
      else if (sel == 2) d = 64'h1C000000 << $urandom_range(0, 8);
      else               d = 64'h303 << $urandom_range(0, 20);
      drive($urandom_range(0, 39) == 0, d, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 5) == 0);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
